// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract engine.
// Latency: n/a (declarations only). Backpressure: n/a.
// Imported by the cell, the interface users and the top.
package addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result bundle between an operand source and the add/sub engine.
// Latency: none (wires only). Backpressure: none; start is only honoured while the engine is idle.
// master = operand source / result consumer, slave = engine.
interface nibble_serial_addsub_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         select;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    modport master (
        output start, op_a, op_b, select,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, op_a, op_b, select,
        output busy, done, result, carry_out, overflow
    );

endinterface

// File: rtl/nibble_serial_addsub_cell.sv
// 4-bit add/subtract cell: sum = a + (b ^ {4{select}}) + cin.
// Latency: combinational. Backpressure: none.
// Also exposes the carry into bit 3 so the caller can form signed overflow.
module nibble_addsub_cell
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                select,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                cin_msb
);

    logic [NIBBLE_W-1:0] b_x;
    logic [NIBBLE_W:0]   full;
    logic [NIBBLE_W-1:0] low;

    assign b_x = b ^ {NIBBLE_W{select == SEL_SUB}};

    assign full = {1'b0, a} + {1'b0, b_x} + {{NIBBLE_W{1'b0}}, cin};

    // Sum of the three low bits; its top bit is the carry into the MSB.
    assign low = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b_x[NIBBLE_W-2:0]}
               + {{(NIBBLE_W-1){1'b0}}, cin};

    assign sum     = full[NIBBLE_W-1:0];
    assign cout    = full[NIBBLE_W];
    assign cin_msb = low[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Wide add/subtract processed one nibble per clock, LSB first; optional SATURATE_EN clamps on overflow.
// Latency: start accepted at edge k -> done high in the cycle after edge k+NIBBLES; busy for NIBBLES+1 cycles.
// Backpressure: none; start while busy is dropped, not queued; result/flags held until the next accepted start.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nibble_serial_addsub_if.slave   bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               sel_q;
    logic [W-1:0]       result_q;
    logic               busy_q;
    logic               done_q;
    logic               cout_q;
    logic               ovf_q;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                nib_cin_msb;
    logic                nib_ovf;
    logic                last;

    assign a_nib   = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib   = b_q[idx*NIBBLE_W +: NIBBLE_W];
    assign last    = (idx == LAST_IDX);
    assign nib_ovf = nib_cin_msb ^ nib_cout;

    nibble_addsub_cell u_cell (
        .a       (a_nib),
        .b       (b_nib),
        .select  (sel_q),
        .cin     (carry),
        .sum     (nib_sum),
        .cout    (nib_cout),
        .cin_msb (nib_cin_msb)
    );

`ifdef SATURATE_EN
    logic [W-1:0] sat_val;
    // Clamp toward the sign of A: positive overflow -> max, negative -> min.
    assign sat_val = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.op_a;
                        b_q      <= bus.op_b;
                        sel_q    <= bus.select;
                        idx      <= '0;
                        // Initial carry of 1 completes A + ~B + 1 for subtract.
                        carry    <= bus.select;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    result_q[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry <= nib_cout;
                    if (last) begin
                        idx    <= '0;
                        cout_q <= nib_cout;
                        ovf_q  <= nib_ovf;
`ifdef SATURATE_EN
                        if (nib_ovf) begin
                            result_q <= sat_val;
                        end
`endif
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (NIBBLES=4) with a result scoreboard.
// Honours SATURATE_EN in its reference model.
module tb_nibble_serial_addsub;

    localparam int NIBBLES = 4;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;
    int   cyc;
    exp_t sb[$];
    exp_t e_mon;

    nibble_serial_addsub_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sel);
        exp_t        r;
        logic [16:0] s;
        if (sel) s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else     s = {1'b0, a} + {1'b0, b};
        r.res = s[15:0];
        r.c   = s[16];
        if (sel) r.v = (a[15] != b[15]) && (s[15] != a[15]);
        else     r.v = (a[15] == b[15]) && (s[15] != a[15]);
`ifdef SATURATE_EN
        if (r.v) r.res = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return r;
    endfunction

    // Scoreboard: every done pulse consumes one expected entry.
    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("done_without_request", 32'(bus.done), 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("result",    32'(bus.result),    32'(e_mon.res));
                check("carry_out", 32'(bus.carry_out), 32'(e_mon.c));
                check("overflow",  32'(bus.overflow),  32'(e_mon.v));
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sel,
                          input bit inject);
        int cyc_n;
        int busy_n;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.select = sel;
        sb.push_back(model(a, b, sel));
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.op_a   = 16'($urandom);
        bus.op_b   = 16'($urandom);
        bus.select = ~sel;
        cyc_n  = 1;
        busy_n = 0;
        while (!bus.done && cyc_n < 20) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            bus.start = (inject && cyc_n == 1);
            cyc_n++;
        end
        bus.start = 1'b0;
        if (bus.busy) busy_n++;
        check("latency", 32'(cyc_n), 32'd5);
        check("busy_cycles", 32'(busy_n), 32'd5);
        @(negedge clk);
        check("done_width", 32'(bus.done), 32'd0);
        check("busy_low", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int   d0;
        int   t_done[3];
        int   wait_n;
        exp_t held;

        checks     = 0;
        errors     = 0;
        done_cnt   = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.select = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(bus.busy),      32'd0);
        check("rst_done",   32'(bus.done),      32'd0);
        check("rst_result", 32'(bus.result),    32'd0);
        check("rst_cout",   32'(bus.carry_out), 32'd0);
        check("rst_ovf",    32'(bus.overflow),  32'd0);
        rst_n = 1'b1;

        run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0003, 16'h000A, 1'b1, 1'b0);
        run_op(16'h000B, 16'h000A, 1'b1, 1'b0);

        // Abort mid-run: nothing pushed, so any later done is flagged.
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'h5555; bus.op_b = 16'h2222; bus.select = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(bus.busy),      32'd0);
        check("abort_done",   32'(bus.done),      32'd0);
        check("abort_result", 32'(bus.result),    32'd0);
        check("abort_cout",   32'(bus.carry_out), 32'd0);
        check("abort_ovf",    32'(bus.overflow),  32'd0);
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);

        // Start pulse during RUN must be dropped.
        d0   = done_cnt;
        held = model(16'h1234, 16'h1111, 1'b0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("ignored_single_done", 32'(done_cnt - d0), 32'd1);
        check("result_held", 32'(bus.result), 32'(held.res));
        check("ignored_not_busy", 32'(bus.busy), 32'd0);

        // Start held high: re-triggers every NIBBLES+2 cycles.
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'hA5C3; bus.op_b = 16'h0FFF; bus.select = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(model(16'hA5C3, 16'h0FFF, 1'b1));
        for (int i = 0; i < 3; i++) begin
            wait_n = 0;
            while (!bus.done && wait_n < 20) begin
                @(negedge clk);
                wait_n++;
            end
            check("b2b_done_seen", 32'(bus.done), 32'd1);
            t_done[i] = cyc;
            if (i == 2) bus.start = 1'b0;
            @(negedge clk);
            check("b2b_done_width", 32'(bus.done), 32'd0);
        end
        check("b2b_period_1", 32'(t_done[1] - t_done[0]), 32'd6);
        check("b2b_period_2", 32'(t_done[2] - t_done[1]), 32'd6);
        repeat (10) @(negedge clk);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd3);
        check("b2b_idle", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
